// File: rtl/avalon_timer_pkg.sv
// Shared register map, bit positions and flag types for the Avalon multi-channel timer.
package avalon_timer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;

  localparam logic [REG_W-1:0] REG_STATUS   = 3'd0;
  localparam logic [REG_W-1:0] REG_CONTROL  = 3'd1;
  localparam logic [REG_W-1:0] REG_PERIOD_L = 3'd2;
  localparam logic [REG_W-1:0] REG_PERIOD_H = 3'd3;
  localparam logic [REG_W-1:0] REG_SNAP_L   = 3'd4;
  localparam logic [REG_W-1:0] REG_SNAP_H   = 3'd5;

  localparam int unsigned STATUS_TO  = 0;
  localparam int unsigned STATUS_RUN = 1;
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  // Field order matches the readback bit positions above.
  typedef struct packed {
    logic run;
    logic to;
  } status_t;

  typedef struct packed {
    logic cont;
    logic ito;
  } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: counter, period, snapshot and RUN/TO/ITO/CONT flags.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h02FAF07F
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] wdata,
  output status_t           status,
  output ctrl_t             ctrl,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  snapshot,
  output logic              irq
);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_nx;
  logic [CNT_W-1:0] period_nx;
  logic [CNT_W-1:0] snapshot_nx;
  status_t          status_nx;
  ctrl_t            ctrl_nx;

  logic status_wr_c;
  logic ctrl_wr_c;
  logic perl_wr_c;
  logic perh_wr_c;
  logic per_wr_c;
  logic snap_wr_c;
  logic at_zero_c;
  logic timeout_c;

  always_comb begin
    status_wr_c = wr_en && (reg_sel == REG_STATUS);
    ctrl_wr_c   = wr_en && (reg_sel == REG_CONTROL);
    perl_wr_c   = wr_en && (reg_sel == REG_PERIOD_L);
    perh_wr_c   = wr_en && (reg_sel == REG_PERIOD_H);
    snap_wr_c   = wr_en && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
    per_wr_c    = perl_wr_c || perh_wr_c;
    at_zero_c   = (counter == '0);
    // A period rewrite landing on zero suppresses the event.
    timeout_c   = status.run && at_zero_c && !per_wr_c;
  end

  // Next-state for counter, period, snapshot and flags.
  always_comb begin
    counter_nx  = counter;
    period_nx   = period;
    snapshot_nx = snapshot;
    status_nx   = status;
    ctrl_nx     = ctrl;

    if (perl_wr_c) period_nx[15:0] = wdata;
    if (perh_wr_c) period_nx[CNT_W-1:16] = wdata[CNT_W-17:0];

    if (per_wr_c) begin
      counter_nx    = period_nx;
      status_nx.run = 1'b0;
    end else if (status.run) begin
      if (at_zero_c) begin
        counter_nx = period;
        if (!ctrl.cont) status_nx.run = 1'b0;
      end else begin
        counter_nx = counter - CNT_W'(1);
      end
    end

    if (ctrl_wr_c) begin
      ctrl_nx.ito  = wdata[CTRL_ITO];
      ctrl_nx.cont = wdata[CTRL_CONT];
      if (wdata[CTRL_STOP])       status_nx.run = 1'b0;
      else if (wdata[CTRL_START]) status_nx.run = 1'b1;
    end

    // Event sets TO even when a clearing STATUS write lands on the same cycle.
    status_nx.to = timeout_c || (status.to && !status_wr_c);

    if (snap_wr_c) snapshot_nx = counter;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter  <= CNT_W'(DEFAULT_PERIOD);
      period   <= CNT_W'(DEFAULT_PERIOD);
      snapshot <= '0;
      status   <= '0;
      ctrl     <= '0;
    end else begin
      counter  <= counter_nx;
      period   <= period_nx;
      snapshot <= snapshot_nx;
      status   <= status_nx;
      ctrl     <= ctrl_nx;
    end
  end

  assign irq = status.to && ctrl.ito;

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM slave with NUM_CH independent timers; top holds address decode and the read path.
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h02FAF07F
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [3+$clog2(NUM_CH)-1:0] address,
  input  logic [DATA_W-1:0]           writedata,
  output logic [DATA_W-1:0]           readdata,
  output logic [NUM_CH-1:0]           irq
);

  localparam int unsigned ADDR_W = 3 + $clog2(NUM_CH);

  logic [ADDR_W-1:0] ch_c;
  logic [REG_W-1:0]  reg_c;
  logic              wr_c;
  logic [DATA_W-1:0] rd_c;

  status_t          status_a [NUM_CH];
  ctrl_t            ctrl_a   [NUM_CH];
  logic [CNT_W-1:0] period_a [NUM_CH];
  logic [CNT_W-1:0] snap_a   [NUM_CH];

  // Channel index is kept full-width so out-of-range indices simply match nothing.
  assign ch_c  = address >> 3;
  assign reg_c = address[REG_W-1:0];
  assign wr_c  = chipselect && !write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_channel (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_c && (ch_c == ADDR_W'(g))),
      .reg_sel  (reg_c),
      .wdata    (writedata),
      .status   (status_a[g]),
      .ctrl     (ctrl_a[g]),
      .period   (period_a[g]),
      .snapshot (snap_a[g]),
      .irq      (irq[g])
    );
  end

  // Read mux over the addressed channel's registers.
  always_comb begin
    rd_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_c == ADDR_W'(i)) begin
        case (reg_c)
          REG_STATUS:   rd_c = DATA_W'(status_a[i]);
          REG_CONTROL:  rd_c = DATA_W'(ctrl_a[i]);
          REG_PERIOD_L: rd_c = period_a[i][15:0];
          REG_PERIOD_H: rd_c = DATA_W'(period_a[i][CNT_W-1:16]);
          REG_SNAP_L:   rd_c = snap_a[i][15:0];
          REG_SNAP_H:   rd_c = DATA_W'(snap_a[i][CNT_W-1:16]);
          default:      rd_c = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_c;
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed self-checking bench for avalon_multi_timer (NUM_CH=2, CNT_W=32).
module tb_avalon_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        write_n;
  logic [3:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [1:0]  irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avalon_multi_timer #(
    .NUM_CH         (2),
    .CNT_W          (32),
    .DEFAULT_PERIOD (32'h02FAF07F)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Called at a negedge; the write is sampled on the next posedge, returns at the following negedge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (readdata !== 16'h0000) begin n_fail++; $display("FAIL reset_readdata: got %h expected %h", readdata, 16'h0000); end
    n_checks++; if (irq !== 2'b00) begin n_fail++; $display("FAIL reset_irq: got %b expected %b", irq, 2'b00); end
    idle(2);
    reset_n = 1'b1;
    rd(4'd2, d);  n_checks++; if (d !== 16'hF07F) begin n_fail++; $display("FAIL reset_ch0_period_l: got %h expected %h", d, 16'hF07F); end
    rd(4'd3, d);  n_checks++; if (d !== 16'h02FA) begin n_fail++; $display("FAIL reset_ch0_period_h: got %h expected %h", d, 16'h02FA); end
    rd(4'd0, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_ch0_status: got %h expected %h", d, 16'h0000); end
    rd(4'd11, d); n_checks++; if (d !== 16'h02FA) begin n_fail++; $display("FAIL reset_ch1_period_h: got %h expected %h", d, 16'h02FA); end
    rd(4'd4, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_ch0_snap_l: got %h expected %h", d, 16'h0000); end
  endtask

  task automatic test_one_shot;
    logic [15:0] d;
    int first;
    wr(4'd2, 16'd5);
    wr(4'd3, 16'd0);
    wr(4'd1, 16'h0005);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (irq[0]) begin first = k; break; end
    end
    n_checks++; if (first != 6) begin n_fail++; $display("FAIL oneshot_to_delay: got %0d expected %0d", first, 6); end
    n_checks++; if (irq !== 2'b01) begin n_fail++; $display("FAIL oneshot_irq: got %b expected %b", irq, 2'b01); end
    rd(4'd0, d); n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL oneshot_status: got %h expected %h", d, 16'h0001); end
  endtask

  task automatic test_continuous;
    int first;
    wr(4'd10, 16'd3);
    wr(4'd11, 16'd0);
    wr(4'd9, 16'h0007);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (irq[1]) begin first = k; break; end
    end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL cont_first_to: got %0d expected %0d", first, 4); end
    wr(4'd8, 16'h0000);
    n_checks++; if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL cont_to_clear: got %b expected %b", irq[1], 1'b0); end
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (irq[1]) begin first = k; break; end
    end
    n_checks++; if (first != 3) begin n_fail++; $display("FAIL cont_next_to: got %0d expected %0d", first, 3); end
  endtask

  // Counter is 3 at entry; the STATUS write lands on the edge where it sits at 0.
  task automatic test_collision;
    logic [15:0] d;
    idle(3);
    wr(4'd8, 16'h0000);
    n_checks++; if (irq[1] !== 1'b1) begin n_fail++; $display("FAIL collision_irq: got %b expected %b", irq[1], 1'b1); end
    rd(4'd8, d); n_checks++; if (d !== 16'h0003) begin n_fail++; $display("FAIL collision_status: got %h expected %h", d, 16'h0003); end
  endtask

  task automatic test_period_rewrite;
    logic [15:0] d;
    wr(4'd1, 16'h0006);
    idle(2);
    wr(4'd2, 16'h0010);
    rd(4'd0, d);  n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL rewrite_status: got %h expected %h", d, 16'h0001); end
    wr(4'd4, 16'h0000);
    rd(4'd4, d);  n_checks++; if (d !== 16'h0010) begin n_fail++; $display("FAIL rewrite_cnt_l: got %h expected %h", d, 16'h0010); end
    rd(4'd5, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rewrite_cnt_h: got %h expected %h", d, 16'h0000); end
    rd(4'd8, d);  n_checks++; if (d !== 16'h0003) begin n_fail++; $display("FAIL rewrite_ch1_status: got %h expected %h", d, 16'h0003); end
    rd(4'd10, d); n_checks++; if (d !== 16'h0003) begin n_fail++; $display("FAIL rewrite_ch1_period: got %h expected %h", d, 16'h0003); end
    n_checks++; if (irq !== 2'b10) begin n_fail++; $display("FAIL rewrite_irq: got %b expected %b", irq, 2'b10); end
  endtask

  task automatic test_snapshot;
    logic [15:0] d;
    wr(4'd2, 16'h0100);
    wr(4'd1, 16'h0004);
    idle(10);
    wr(4'd4, 16'h0000);
    n_checks++; if (readdata !== 16'h0010) begin n_fail++; $display("FAIL snap_latency: got %h expected %h", readdata, 16'h0010); end
    rd(4'd4, d); n_checks++; if (d !== 16'h00F6) begin n_fail++; $display("FAIL snap_l: got %h expected %h", d, 16'h00F6); end
    rd(4'd5, d); n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL snap_h: got %h expected %h", d, 16'h0000); end
  endtask

  task automatic test_start_stop;
    logic [15:0] d;
    wr(4'd2, 16'h0040);
    wr(4'd1, 16'h0004);
    wr(4'd1, 16'h0008);
    idle(3);
    wr(4'd4, 16'h0000);
    rd(4'd4, d);  n_checks++; if (d !== 16'h003F) begin n_fail++; $display("FAIL stop_hold: got %h expected %h", d, 16'h003F); end
    rd(4'd0, d);  n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL stop_status: got %h expected %h", d, 16'h0001); end
    wr(4'd1, 16'h000C);
    idle(2);
    rd(4'd0, d);  n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL startstop_status: got %h expected %h", d, 16'h0001); end
    wr(4'd4, 16'h0000);
    rd(4'd4, d);  n_checks++; if (d !== 16'h003F) begin n_fail++; $display("FAIL startstop_hold: got %h expected %h", d, 16'h003F); end
    rd(4'd1, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL control_read: got %h expected %h", d, 16'h0000); end
    rd(4'd9, d);  n_checks++; if (d !== 16'h0003) begin n_fail++; $display("FAIL ch1_control_read: got %h expected %h", d, 16'h0003); end
    rd(4'd6, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reg6_read: got %h expected %h", d, 16'h0000); end
    wr(4'd15, 16'hFFFF);
    rd(4'd15, d); n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reg7_read: got %h expected %h", d, 16'h0000); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    address = 4'd8;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (readdata !== 16'h0000) begin n_fail++; $display("FAIL midreset_readdata: got %h expected %h", readdata, 16'h0000); end
    n_checks++; if (irq !== 2'b00) begin n_fail++; $display("FAIL midreset_irq: got %b expected %b", irq, 2'b00); end
    idle(2);
    reset_n = 1'b1;
    rd(4'd2, d);  n_checks++; if (d !== 16'hF07F) begin n_fail++; $display("FAIL midreset_period_l: got %h expected %h", d, 16'hF07F); end
    rd(4'd3, d);  n_checks++; if (d !== 16'h02FA) begin n_fail++; $display("FAIL midreset_period_h: got %h expected %h", d, 16'h02FA); end
    rd(4'd0, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midreset_ch0_status: got %h expected %h", d, 16'h0000); end
    rd(4'd8, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midreset_ch1_status: got %h expected %h", d, 16'h0000); end
    idle(20);
    rd(4'd8, d);  n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midreset_ch1_idle: got %h expected %h", d, 16'h0000); end
    n_checks++; if (irq !== 2'b00) begin n_fail++; $display("FAIL midreset_irq_idle: got %b expected %b", irq, 2'b00); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_continuous();
    test_collision();
    test_period_rewrite();
    test_snapshot();
    test_start_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_multi_timer.md
AVALON_MULTI_TIMER -- requirements
Module: avalon_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of independent timer channels (1..4).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the counter and period width in bits (17..32).
REQ-003 SHALL have parameter DEFAULT_PERIOD, default 32'h02FAF07F, meaning the reset period of every channel, truncated to CNT_W.
REQ-004 SHALL have port clk, input, 1 bit: the system clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port chipselect, input, 1 bit: Avalon slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 SHALL have port address, input, 3+clog2(NUM_CH) bits, decoded as {channel, reg[2:0]}.
REQ-009 SHALL have port writedata, input, 16 bits: write data.
REQ-010 SHALL have port readdata, output, 16 bits: registered read data.
REQ-011 SHALL have port irq, output, NUM_CH bits: per-channel interrupt, level.

Function
REQ-012 SHALL implement this per-channel register map:
- reg0 STATUS: bit0 TO, bit1 RUN; any write clears TO.
- reg1 CONTROL: bit0 ITO, bit1 CONT, bit2 START (write-only pulse), bit3 STOP (write-only pulse); reads return {0, CONT, ITO}.
- reg2 PERIOD_L: period[15:0].
- reg3 PERIOD_H: period[CNT_W-1:16].
- reg4 SNAP_L / reg5 SNAP_H: snapshot; any write to reg4 or reg5 captures the live counter.
- reg6 and reg7: read 0; writes ignored.
REQ-013 SHALL update readdata every cycle with the addressed register's value, giving 1-cycle read latency; unused bits read 0.
REQ-014 SHALL, while RUN=1, decrement the counter by 1 per clock; when the counter is 0 it SHALL reload the period on the next clock, so a period P gives a timeout every P+1 cycles.
REQ-015 SHALL generate timeout_event on the cycle the counter first equals 0 while RUN=1, and SHALL set TO on the following clock.
REQ-016 SHALL, in one-shot mode (CONT=0), clear RUN on the same clock as the reload at zero; in continuous mode (CONT=1), RUN SHALL stay set.
REQ-017 SHALL, on a write to PERIOD_L or PERIOD_H, update that half, clear RUN, and load the counter with the new full period on the next clock.
REQ-018 SHALL set RUN on the clock after a CONTROL write with START=1, counting from the current counter value.
REQ-019 SHALL clear RUN on the clock after a CONTROL write with STOP=1; the counter SHALL hold its value.
REQ-020 SHALL give STOP precedence when START and STOP are written together, leaving RUN=0.
REQ-021 SHALL give set precedence to TO when a STATUS write and a timeout_event occur in the same cycle, so TO=1 and no event is lost.
REQ-022 SHALL, when a period write coincides with counter=0, skip timeout_event and load the new period.
REQ-023 SHALL drive irq[n] = TO[n] AND ITO[n] combinationally from registers.
REQ-024 SHALL ignore writes addressed to channel indices >= NUM_CH, and reads of those indices SHALL return 0.

Reset
REQ-025 SHALL, on reset_n low, immediately set in every channel: counter=DEFAULT_PERIOD, period=DEFAULT_PERIOD, snapshot=0, RUN=0, TO=0, ITO=0, CONT=0; also readdata=0 and irq=0.
REQ-026 SHALL, on reset assertion mid-count, abandon the count; after release, channels SHALL stay idle until START.

Structure
REQ-027 SHALL place the register offsets (STATUS..SNAP_H) and the CONTROL/STATUS bit positions in the shared package avalon_timer_pkg.
REQ-028 SHALL implement each channel as sub-module timer_channel (counter, period, snapshot, RUN/TO/ITO/CONT), instantiated NUM_CH times by a generate loop.
REQ-029 SHALL keep address decode, the read mux and the readdata register in the top level.

Verification (NUM_CH=2, CNT_W=32)
REQ-030 SHALL verify one-shot: ch0 period=5, CONTROL=0x5 -> TO set exactly 6 cycles after RUN rises, RUN clears, irq[0]=1, irq[1]=0.
REQ-031 SHALL verify continuous: ch1 period=3, CONTROL=0x7 -> TO events every 4 cycles; a STATUS write clears TO; irq[1] follows TO.
REQ-032 SHALL verify collision: a STATUS write on the timeout_event cycle -> TO=1 afterwards.
REQ-033 SHALL verify period rewrite: PERIOD_L=0x0010 while running -> RUN=0 and counter=0x00000010 on the next clock; other channel unaffected.
REQ-034 SHALL verify snapshot: write reg4 mid-count -> SNAP_L/SNAP_H read back the counter value at the write cycle, read latency 1.
REQ-035 SHALL verify reset: reset_n low mid-count -> all outputs 0; after release, period reads 0xF07F/0x02FA and RUN=0.
